penentu_aksi: RTL and testbench

Sequential inverse of the grid-world state-transition block: consumes a stream of observed agent states on a 5x5 grid (states 1..25, row-major) and recovers, per transition, the action code (right/up/left/down/blocked) that produced it, flagging transitions no single action can explain. Sits between the environment/trajectory source and the Q-table update logic, so replayed trajectories can be turned back into (state, action, next_state) tuples.

---
 rtl/grid_pkg.sv | 34 +++
 rtl/grid_move_classify.sv | 55 +++++
 rtl/penentu_aksi.sv | 154 +++++++++++++++
 tb/tb_penentu_aksi.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// +--------------------------------------------------------------------+
// | grid_pkg: grid geometry, action codes and FSM states for the       |
// | grid-world transition/decode blocks.            Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

package grid_pkg;

  localparam int GRID_W   = 5;
  localparam int GRID_H   = 5;
  localparam int STATE_W  = 6;
  localparam int ACTION_W = 4;

  localparam logic [ACTION_W-1:0] ACT_RIGHT   = 4'b0000;
  localparam logic [ACTION_W-1:0] ACT_UP      = 4'b0001;
  localparam logic [ACTION_W-1:0] ACT_LEFT    = 4'b0010;
  localparam logic [ACTION_W-1:0] ACT_DOWN    = 4'b0011;
  localparam logic [ACTION_W-1:0] ACT_BLOCKED = 4'b0100;
  localparam logic [ACTION_W-1:0] ACT_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

  // States are numbered from 1; zero and anything past the last cell are off-grid.
  function automatic logic state_in_range(input logic [STATE_W-1:0] s, input int n_states);
    return (s != '0) && (int'(s) <= n_states);
  endfunction

endpackage

`default_nettype wire

// File: rtl/grid_move_classify.sv
// +--------------------------------------------------------------------+
// | grid_move_classify: maps a (prev, next) state pair to the single   |
// | action that explains it, or flags it illegal.   Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module grid_move_classify
  import grid_pkg::*;
#(
  parameter int GRID_W = grid_pkg::GRID_W,
  parameter int GRID_H = grid_pkg::GRID_H
) (
  input  logic [STATE_W-1:0]  prev_state,
  input  logic [STATE_W-1:0]  next_state,
  output logic [ACTION_W-1:0] action,
  output logic                illegal
);

  localparam int N_STATES = GRID_W * GRID_H;

  int p;
  int n;
  int p_col;
  int p_row;

  always_comb begin
    p       = int'(prev_state);
    n       = int'(next_state);
    p_col   = (p - 1) % GRID_W;
    p_row   = (p - 1) / GRID_W;
    action  = ACT_ILLEGAL;
    illegal = 1'b1;
    if (state_in_range(prev_state, N_STATES) && state_in_range(next_state, N_STATES)) begin
      illegal = 1'b0;
      // Column/row guards reject moves that would wrap across a grid edge.
      if (n == p) begin
        action = ACT_BLOCKED;
      end else if ((n == p + 1) && (p_col < GRID_W - 1)) begin
        action = ACT_RIGHT;
      end else if ((n == p - 1) && (p_col > 0)) begin
        action = ACT_LEFT;
      end else if ((n == p - GRID_W) && (p_row > 0)) begin
        action = ACT_UP;
      end else if ((n == p + GRID_W) && (p_row < GRID_H - 1)) begin
        action = ACT_DOWN;
      end else begin
        action  = ACT_ILLEGAL;
        illegal = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/penentu_aksi.sv
// +--------------------------------------------------------------------+
// | penentu_aksi: recovers per-transition action codes from a stream   |
// | of observed grid states, one tuple per cycle.   Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module penentu_aksi
  import grid_pkg::*;
#(
  parameter int GRID_W     = grid_pkg::GRID_W,
  parameter int GRID_H     = grid_pkg::GRID_H,
  parameter int GOAL_STATE = 25,
  parameter int MAX_STEPS  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] start_state,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_prev_state,
  output logic [5:0] out_state,
  output logic [3:0] out_action,
  output logic       out_illegal,
  output logic       episode_done,
  output logic [7:0] step_count
);

  localparam int N_STATES = GRID_W * GRID_H;
  localparam logic [STATE_W-1:0] GOAL_C      = GOAL_STATE[STATE_W-1:0];
  localparam logic [7:0]         MAX_STEPS_C = MAX_STEPS[7:0];

  fsm_state_e           state_q, state_d;
  logic [STATE_W-1:0]   prev_q, prev_d;
  logic [STATE_W-1:0]   out_prev_q, out_prev_d;
  logic [STATE_W-1:0]   out_state_q, out_state_d;
  logic [ACTION_W-1:0]  out_action_q, out_action_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_illegal_q, out_illegal_d;
  logic                 done_q, done_d;
  logic [7:0]           step_q, step_d;

  logic [ACTION_W-1:0]  cls_action;
  logic                 cls_illegal;
  logic                 accept;
  logic                 out_fire;
  logic [7:0]           step_inc;

  grid_move_classify #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_classify (
    .prev_state (prev_q),
    .next_state (in_state),
    .action     (cls_action),
    .illegal    (cls_illegal)
  );

  // The output register is 1-deep, so a new tuple may enter only as the old one leaves.
  assign in_ready = (state_q == ST_TRACK) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign step_inc = step_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    step_d        = step_q;
    out_valid_d   = out_valid_q;
    out_prev_d    = out_prev_q;
    out_state_d   = out_state_q;
    out_action_d  = out_action_q;
    out_illegal_d = out_illegal_q;
    done_d        = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prev_d  = start_state;
          step_d  = 8'd0;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (accept) begin
          out_valid_d   = 1'b1;
          out_prev_d    = prev_q;
          out_state_d   = in_state;
          out_action_d  = cls_action;
          out_illegal_d = cls_illegal;
          step_d        = step_inc;
          // An off-grid observation cannot serve as the origin of the next move.
          if (state_in_range(in_state, N_STATES)) begin
            prev_d = in_state;
          end
          if ((in_state == GOAL_C) || (step_inc == MAX_STEPS_C)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      prev_q        <= '0;
      step_q        <= '0;
      out_valid_q   <= 1'b0;
      out_prev_q    <= '0;
      out_state_q   <= '0;
      out_action_q  <= ACT_RIGHT;
      out_illegal_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      step_q        <= step_d;
      out_valid_q   <= out_valid_d;
      out_prev_q    <= out_prev_d;
      out_state_q   <= out_state_d;
      out_action_q  <= out_action_d;
      out_illegal_q <= out_illegal_d;
      done_q        <= done_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_prev_state = out_prev_q;
  assign out_state      = out_state_q;
  assign out_action     = out_action_q;
  assign out_illegal    = out_illegal_q;
  assign episode_done   = done_q;
  assign step_count     = step_q;

endmodule

`default_nettype wire

// File: tb/tb_penentu_aksi.sv
// +--------------------------------------------------------------------+
// | tb_penentu_aksi: scoreboard bench for penentu_aksi (default and    |
// | MAX_STEPS=3 instances share one stimulus).      Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_penentu_aksi;

  localparam int W = 5;
  localparam int H = 5;

  typedef struct {
    logic [5:0] p;
    logic [5:0] n;
    logic [3:0] a;
    logic       il;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] start_state;
  logic       in_valid;
  logic [5:0] in_state;
  logic       out_ready;
  logic       sel;

  logic       a_in_ready, a_out_valid, a_out_illegal, a_episode_done;
  logic [5:0] a_out_prev, a_out_state;
  logic [3:0] a_out_action;
  logic [7:0] a_step;
  logic       b_in_ready, b_out_valid, b_out_illegal, b_episode_done;
  logic [5:0] b_out_prev, b_out_state;
  logic [3:0] b_out_action;
  logic [7:0] b_step;

  logic       m_in_ready, m_out_valid, m_out_illegal, m_episode_done;
  logic [5:0] m_out_prev, m_out_state;
  logic [3:0] m_out_action;
  logic [7:0] m_step;

  int         n_vec = 0;
  int         n_err = 0;
  int         stalls = 0;
  exp_t       sb_q[$];
  logic [5:0] prev_m;

  always #5 clk = ~clk;

  penentu_aksi dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_state(start_state),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_state(in_state),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_prev_state(a_out_prev),
    .out_state(a_out_state), .out_action(a_out_action), .out_illegal(a_out_illegal),
    .episode_done(a_episode_done), .step_count(a_step)
  );

  penentu_aksi #(.MAX_STEPS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_state(start_state),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_state(in_state),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_prev_state(b_out_prev),
    .out_state(b_out_state), .out_action(b_out_action), .out_illegal(b_out_illegal),
    .episode_done(b_episode_done), .step_count(b_step)
  );

  assign m_in_ready     = sel ? b_in_ready     : a_in_ready;
  assign m_out_valid    = sel ? b_out_valid    : a_out_valid;
  assign m_out_illegal  = sel ? b_out_illegal  : a_out_illegal;
  assign m_episode_done = sel ? b_episode_done : a_episode_done;
  assign m_out_prev     = sel ? b_out_prev     : a_out_prev;
  assign m_out_state    = sel ? b_out_state    : a_out_state;
  assign m_out_action   = sel ? b_out_action   : a_out_action;
  assign m_step         = sel ? b_step         : a_step;

  // Reference decode on (row, col) coordinates.
  function automatic void model(input int p, input int n, output logic [3:0] a, output logic il);
    int pr, pc, nr, nc;
    a  = 4'b1111;
    il = 1'b1;
    if (p >= 1 && p <= W*H && n >= 1 && n <= W*H) begin
      pr = (p - 1) / W;  pc = (p - 1) % W;
      nr = (n - 1) / W;  nc = (n - 1) % W;
      if (nr == pr && nc == pc)          begin a = 4'b0100; il = 1'b0; end
      else if (nr == pr && nc == pc + 1) begin a = 4'b0000; il = 1'b0; end
      else if (nr == pr && nc == pc - 1) begin a = 4'b0010; il = 1'b0; end
      else if (nc == pc && nr == pr - 1) begin a = 4'b0001; il = 1'b0; end
      else if (nc == pc && nr == pr + 1) begin a = 4'b0011; il = 1'b0; end
    end
  endfunction

  // Scores the tuple that will hand off at the coming edge, then advances to the next negedge.
  task automatic tick();
    exp_t e;
    if (rst_n && m_out_valid && out_ready) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tuple: got prev=%0d state=%0d action=%b, wanted no tuple",
                 m_out_prev, m_out_state, m_out_action);
      end else begin
        e = sb_q.pop_front();
        if ({m_out_prev, m_out_state, m_out_action, m_out_illegal} !== {e.p, e.n, e.a, e.il}) begin
          n_err++;
          $display("FAIL tuple: got prev=%0d state=%0d action=%b illegal=%b, wanted prev=%0d state=%0d action=%b illegal=%b",
                   m_out_prev, m_out_state, m_out_action, m_out_illegal, e.p, e.n, e.a, e.il);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [5:0] s);
    exp_t e;
    int   waits = 0;
    in_valid = 1'b1;
    in_state = s;
    #1;
    while (!m_in_ready && waits < 20) begin
      tick();
      waits++;
    end
    if (!m_in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_state=%0d not accepted, got in_ready=0 wanted 1", s);
      in_valid = 1'b0;
      return;
    end
    stalls += waits;
    e.p = prev_m;
    e.n = s;
    model(int'(prev_m), int'(s), e.a, e.il);
    sb_q.push_back(e);
    if (s >= 1 && s <= W*H) prev_m = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_ep(input logic [5:0] s);
    start       = 1'b1;
    start_state = s;
    tick();
    start  = 1'b0;
    prev_m = s;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain_queue(input string name);
    int k = 0;
    while (sb_q.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d tuples outstanding, wanted 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    start_state = '0; in_state = '0; sel = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({m_in_ready, m_out_valid, m_out_illegal, m_episode_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b, wanted 0000", {m_in_ready, m_out_valid, m_out_illegal, m_episode_done});
    end
    n_vec++;
    if ({m_out_prev, m_out_state} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_states: got prev=%0d state=%0d, wanted 0 0", m_out_prev, m_out_state);
    end
    n_vec++;
    if (m_out_action !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_action: got %b, wanted 0000", m_out_action);
    end
    n_vec++;
    if (m_step !== 8'd0) begin
      n_err++;
      $display("FAIL reset_step: got %0d, wanted 0", m_step);
    end
  endtask

  task automatic test_stream();
    logic [5:0] seq [4] = '{6'd2, 6'd7, 6'd12, 6'd13};
    apply_reset();
    sel = 1'b0;
    out_ready = 1'b1;
    start_ep(6'd1);
    stalls = 0;
    foreach (seq[i]) send(seq[i]);
    n_vec++;
    if (stalls != 0) begin
      n_err++;
      $display("FAIL stream_rate: got %0d stall cycles, wanted 0", stalls);
    end
    n_vec++;
    if (m_step !== 8'd4) begin
      n_err++;
      $display("FAIL stream_step: got %0d, wanted 4", m_step);
    end
    drain_queue("stream");
  endtask

  task automatic test_row_wrap();
    apply_reset();
    out_ready = 1'b1;
    start_ep(6'd5);
    send(6'd6);
    send(6'd5);
    drain_queue("row_wrap");
  endtask

  task automatic test_blocked_oor();
    apply_reset();
    out_ready = 1'b1;
    start_ep(6'd1);
    send(6'd1);
    send(6'd0);
    send(6'd2);
    drain_queue("blocked_oor");
  endtask

  task automatic test_drain_hold();
    int seen = 0;
    apply_reset();
    out_ready = 1'b1;
    start_ep(6'd19);
    send(6'd20);
    send(6'd25);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = 6'd24;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({m_out_valid, m_in_ready, m_episode_done, m_out_prev, m_out_state, m_out_action} !==
          {1'b1, 1'b0, 1'b0, 6'd20, 6'd25, 4'b0011}) begin
        n_err++;
        $display("FAIL drain_hold: got valid=%b ready=%b done=%b prev=%0d state=%0d action=%b, wanted 1 0 0 20 25 0011",
                 m_out_valid, m_in_ready, m_episode_done, m_out_prev, m_out_state, m_out_action);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (m_episode_done !== 1'b1) begin
      n_err++;
      $display("FAIL drain_done_pulse: got %b, wanted 1", m_episode_done);
    end
    tick();
    n_vec++;
    if ({m_episode_done, m_in_ready, m_step} !== {1'b0, 1'b0, 8'd2}) begin
      n_err++;
      $display("FAIL drain_after: got done=%b ready=%b step=%0d, wanted 0 0 2", m_episode_done, m_in_ready, m_step);
    end
    drain_queue("drain");
  endtask

  task automatic test_max_steps();
    int seen = 0;
    apply_reset();
    sel = 1'b1;
    out_ready = 1'b1;
    start_ep(6'd13);
    for (int i = 0; i < 3; i++) send(6'd13);
    in_valid = 1'b1;
    in_state = 6'd14;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (m_in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL max_steps_ready: cycle %0d got in_ready=%b, wanted 0", i, m_in_ready);
      end
      tick();
      if (m_episode_done === 1'b1) seen++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (seen != 1) begin
      n_err++;
      $display("FAIL max_steps_done: got %0d done cycles, wanted 1", seen);
    end
    n_vec++;
    if (m_step !== 8'd3) begin
      n_err++;
      $display("FAIL max_steps_step: got %0d, wanted 3", m_step);
    end
    drain_queue("max_steps");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sel = 1'b0;
    out_ready = 1'b0;
    start_ep(6'd1);
    send(6'd2);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m_out_valid, m_in_ready, m_out_illegal, m_episode_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_flags: got %b, wanted 0000", {m_out_valid, m_in_ready, m_out_illegal, m_episode_done});
    end
    n_vec++;
    if ({m_out_prev, m_out_state, m_out_action, m_step} !== 24'd0) begin
      n_err++;
      $display("FAIL midreset_regs: got prev=%0d state=%0d action=%b step=%0d, wanted all 0",
               m_out_prev, m_out_state, m_out_action, m_step);
    end
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (m_episode_done !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_done: cycle %0d got %b, wanted 0", i, m_episode_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_row_wrap();
    test_blocked_oor();
    test_drain_hold();
    test_max_steps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
